// File: rtl/nh_lcd_i80_engine.sv
// nh_lcd_i80_engine: 8080-style parallel LCD bus engine.
// A single FSM runs both paths. A command path issues single read or write beats.
// A frame path streams pixel words from an internal FIFO, one bus beat per
// DATA_WIDTH slice, and can first wait for a tearing-effect rising edge.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   i_enable                       blocks new transfers; aborts a running frame
//   i_wr_low/high_cycles,
//   i_rd_low_cycles                strobe timing in cycles (0 behaves as 1)
//   i_cmd_*, o_cmd_*               single command beat request and status
//   i_frame_start, i_num_pixels,
//   i_enable_tearing,
//   i_tearing_effect               frame request and TE sync
//   o_frame_busy, o_frame_done     frame status
//   i_fifo_*, o_fifo_*             pixel word FIFO push side and status
//   o_register_data_sel, o_write_n,
//   o_read_n, o_data_out,
//   o_data_oe, i_data_in           panel bus
module nh_lcd_i80_engine #(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH_LOG2 = 6,
  parameter int unsigned TIMER_WIDTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_enable,
  input  logic [TIMER_WIDTH-1:0]     i_wr_low_cycles,
  input  logic [TIMER_WIDTH-1:0]     i_wr_high_cycles,
  input  logic [TIMER_WIDTH-1:0]     i_rd_low_cycles,
  input  logic                       i_cmd_stb,
  input  logic                       i_cmd_read,
  input  logic                       i_cmd_is_param,
  input  logic [DATA_WIDTH-1:0]      i_cmd_data,
  output logic [DATA_WIDTH-1:0]      o_cmd_data,
  output logic                       o_cmd_busy,
  output logic                       o_cmd_done,
  input  logic                       i_frame_start,
  input  logic [31:0]                i_num_pixels,
  input  logic                       i_enable_tearing,
  input  logic                       i_tearing_effect,
  output logic                       o_frame_busy,
  output logic                       o_frame_done,
  input  logic                       i_fifo_stb,
  input  logic [31:0]                i_fifo_data,
  output logic                       o_fifo_full,
  output logic [FIFO_DEPTH_LOG2:0]   o_fifo_count,
  output logic                       o_fifo_overflow,
  output logic                       o_register_data_sel,
  output logic                       o_write_n,
  output logic                       o_read_n,
  output logic [DATA_WIDTH-1:0]      o_data_out,
  output logic                       o_data_oe,
  input  logic [DATA_WIDTH-1:0]      i_data_in
);

  localparam int unsigned NBEATS = 32 / DATA_WIDTH;
  localparam int unsigned SW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned DEPTH  = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [2:0] {
    S_IDLE, S_TE_WAIT, S_FETCH, S_WR_LOW, S_WR_HIGH, S_RD_LOW, S_RD_HIGH
  } state_e;

  state_e                     state_q;
  logic [TIMER_WIDTH-1:0]     cnt_q;
  logic                       frame_q, last_q;
  logic [31:0]                num_q, beat_q;
  logic [SW-1:0]              slice_q;
  logic                       wn_q, rn_q, rs_q, oe_q, cmd_done_q, frame_done_q;
  logic [DATA_WIDTH-1:0]      dout_q, cmd_data_q;
  logic                       te_s1_q, te_s2_q, te_s3_q;

  logic [31:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [FIFO_DEPTH_LOG2:0]   count_q;
  logic                       ovf_q;

  logic [TIMER_WIDTH-1:0]     wr_low_m1, wr_high_m1, rd_low_m1;
  logic                       fifo_empty, fifo_full, fifo_push, fifo_pop, fifo_flush;
  logic [31:0]                fifo_head, beat_next;
  logic                       last_beat, last_slice, te_rise;
  logic [4:0]                 slice_sh;
  logic [DATA_WIDTH-1:0]      slice_data;

  always_comb begin
    wr_low_m1  = (i_wr_low_cycles  == '0) ? '0 : i_wr_low_cycles  - TIMER_WIDTH'(1);
    wr_high_m1 = (i_wr_high_cycles == '0) ? '0 : i_wr_high_cycles - TIMER_WIDTH'(1);
    rd_low_m1  = (i_rd_low_cycles  == '0) ? '0 : i_rd_low_cycles  - TIMER_WIDTH'(1);
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == (FIFO_DEPTH_LOG2+1)'(DEPTH));
    fifo_head  = mem_q[rptr_q];
    beat_next  = beat_q + 32'd1;
    last_beat  = (beat_next == num_q);
    last_slice = (slice_q == SW'(NBEATS - 1));
    te_rise    = te_s2_q & ~te_s3_q;
    // MSB slice goes out first
    slice_sh   = 5'((NBEATS - 1 - 32'(slice_q)) * DATA_WIDTH);
    slice_data = fifo_head[slice_sh +: DATA_WIDTH];
    // Pop when the beat's slice is launched. The data is already captured in dout_q.
    fifo_pop   = (state_q == S_FETCH) && i_enable && !fifo_empty && (last_slice || last_beat);
    // Abort paths back to IDLE discard whatever pixels remain
    fifo_flush = !i_enable && ((state_q == S_FETCH) || (state_q == S_TE_WAIT) ||
                 ((state_q == S_WR_HIGH) && frame_q && (cnt_q == '0) && !last_q));
    fifo_push  = i_fifo_stb && !fifo_full && !fifo_flush;
  end

  always_ff @(posedge clk) begin
    if (fifo_push) mem_q[wptr_q] <= i_fifo_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (i_fifo_stb && fifo_full) ovf_q <= 1'b1;
      if (fifo_flush) begin
        wptr_q  <= '0;
        rptr_q  <= '0;
        count_q <= '0;
      end else begin
        if (fifo_push) wptr_q <= wptr_q + 1'b1;
        if (fifo_pop)  rptr_q <= rptr_q + 1'b1;
        if (fifo_push && !fifo_pop)      count_q <= count_q + 1'b1;
        else if (!fifo_push && fifo_pop) count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      frame_q      <= 1'b0;
      last_q       <= 1'b0;
      num_q        <= '0;
      beat_q       <= '0;
      slice_q      <= '0;
      wn_q         <= 1'b1;
      rn_q         <= 1'b1;
      rs_q         <= 1'b1;
      oe_q         <= 1'b0;
      dout_q       <= '0;
      cmd_data_q   <= '0;
      cmd_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      te_s1_q      <= 1'b0;
      te_s2_q      <= 1'b0;
      te_s3_q      <= 1'b0;
    end else begin
      cmd_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      te_s1_q      <= i_tearing_effect;
      te_s2_q      <= te_s1_q;
      te_s3_q      <= te_s2_q;
      case (state_q)
        S_IDLE: begin
          if (i_enable && i_cmd_stb) begin
            frame_q <= 1'b0;
            rs_q    <= i_cmd_is_param;
            if (i_cmd_read) begin
              state_q <= S_RD_LOW;
              rn_q    <= 1'b0;
              oe_q    <= 1'b0;
              cnt_q   <= rd_low_m1;
            end else begin
              state_q <= S_WR_LOW;
              wn_q    <= 1'b0;
              oe_q    <= 1'b1;
              dout_q  <= i_cmd_data;
              cnt_q   <= wr_low_m1;
            end
          end else if (i_enable && i_frame_start) begin
            num_q   <= i_num_pixels;
            beat_q  <= '0;
            slice_q <= '0;
            rs_q    <= 1'b1;
            if (i_num_pixels == '0) begin
              frame_done_q <= 1'b1;
            end else begin
              frame_q <= 1'b1;
              state_q <= i_enable_tearing ? S_TE_WAIT : S_FETCH;
            end
          end
        end
        S_TE_WAIT: begin
          if (!i_enable) begin
            state_q <= S_IDLE;
            frame_q <= 1'b0;
          end else if (te_rise) begin
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (!i_enable) begin
            state_q <= S_IDLE;
            frame_q <= 1'b0;
          end else if (!fifo_empty) begin
            state_q <= S_WR_LOW;
            wn_q    <= 1'b0;
            oe_q    <= 1'b1;
            dout_q  <= slice_data;
            cnt_q   <= wr_low_m1;
            beat_q  <= beat_next;
            last_q  <= last_beat;
            slice_q <= fifo_pop ? '0 : slice_q + SW'(1);
          end
        end
        S_WR_LOW: begin
          if (cnt_q == '0) begin
            state_q <= S_WR_HIGH;
            wn_q    <= 1'b1;
            cnt_q   <= wr_high_m1;
          end else begin
            cnt_q <= cnt_q - TIMER_WIDTH'(1);
          end
        end
        S_WR_HIGH: begin
          if (cnt_q == '0) begin
            oe_q <= 1'b0;
            if (!frame_q) begin
              state_q    <= S_IDLE;
              cmd_done_q <= 1'b1;
            end else if (last_q) begin
              state_q      <= S_IDLE;
              frame_q      <= 1'b0;
              frame_done_q <= 1'b1;
            end else if (!i_enable) begin
              state_q <= S_IDLE;
              frame_q <= 1'b0;
            end else begin
              state_q <= S_FETCH;
            end
          end else begin
            cnt_q <= cnt_q - TIMER_WIDTH'(1);
          end
        end
        S_RD_LOW: begin
          if (cnt_q == '0) begin
            state_q    <= S_RD_HIGH;
            rn_q       <= 1'b1;
            cmd_data_q <= i_data_in;
            cnt_q      <= wr_high_m1;
          end else begin
            cnt_q <= cnt_q - TIMER_WIDTH'(1);
          end
        end
        S_RD_HIGH: begin
          if (cnt_q == '0) begin
            state_q    <= S_IDLE;
            cmd_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - TIMER_WIDTH'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_cmd_data          = cmd_data_q;
  assign o_cmd_busy          = (state_q != S_IDLE);
  assign o_cmd_done          = cmd_done_q;
  assign o_frame_busy        = frame_q;
  assign o_frame_done        = frame_done_q;
  assign o_fifo_full         = fifo_full;
  assign o_fifo_count        = count_q;
  assign o_fifo_overflow     = ovf_q;
  assign o_register_data_sel = rs_q;
  assign o_write_n           = wn_q;
  assign o_read_n            = rn_q;
  assign o_data_out          = dout_q;
  assign o_data_oe           = oe_q;

endmodule

// File: tb/tb_nh_lcd_i80_engine.sv
// Directed testbench for nh_lcd_i80_engine with DATA_WIDTH=8.
// Each step pushes the write beats it expects onto a queue. A monitor pops one
// entry on every write_n falling edge and checks D/C, data and output enable.
module tb_nh_lcd_i80_engine;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_enable;
  logic [3:0]    i_wr_low_cycles, i_wr_high_cycles, i_rd_low_cycles;
  logic          i_cmd_stb, i_cmd_read, i_cmd_is_param;
  logic [DW-1:0] i_cmd_data, o_cmd_data;
  logic          o_cmd_busy, o_cmd_done;
  logic          i_frame_start;
  logic [31:0]   i_num_pixels;
  logic          i_enable_tearing, i_tearing_effect;
  logic          o_frame_busy, o_frame_done;
  logic          i_fifo_stb;
  logic [31:0]   i_fifo_data;
  logic          o_fifo_full;
  logic [6:0]    o_fifo_count;
  logic          o_fifo_overflow;
  logic          o_register_data_sel, o_write_n, o_read_n;
  logic [DW-1:0] o_data_out;
  logic          o_data_oe;
  logic [DW-1:0] i_data_in;

  nh_lcd_i80_engine #(.DATA_WIDTH(8), .FIFO_DEPTH_LOG2(6), .TIMER_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_wr_low_cycles(i_wr_low_cycles), .i_wr_high_cycles(i_wr_high_cycles),
    .i_rd_low_cycles(i_rd_low_cycles),
    .i_cmd_stb(i_cmd_stb), .i_cmd_read(i_cmd_read), .i_cmd_is_param(i_cmd_is_param),
    .i_cmd_data(i_cmd_data), .o_cmd_data(o_cmd_data), .o_cmd_busy(o_cmd_busy),
    .o_cmd_done(o_cmd_done), .i_frame_start(i_frame_start), .i_num_pixels(i_num_pixels),
    .i_enable_tearing(i_enable_tearing), .i_tearing_effect(i_tearing_effect),
    .o_frame_busy(o_frame_busy), .o_frame_done(o_frame_done),
    .i_fifo_stb(i_fifo_stb), .i_fifo_data(i_fifo_data), .o_fifo_full(o_fifo_full),
    .o_fifo_count(o_fifo_count), .o_fifo_overflow(o_fifo_overflow),
    .o_register_data_sel(o_register_data_sel), .o_write_n(o_write_n), .o_read_n(o_read_n),
    .o_data_out(o_data_out), .o_data_oe(o_data_oe), .i_data_in(i_data_in)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];   // {register_data_sel, data}

  // Monitor state
  int   nfalls = 0, fall_cyc = 0;
  int   low_run = 0, last_low = 0, high_run = 0, last_high = 0;
  int   rlow_run = 0, last_rlow = 0, fdone_cnt = 0;
  logic rd_oe_bad = 1'b0;
  logic wn_prev = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] d);
    i_fifo_stb  = 1'b1;
    i_fifo_data = d;
    tick();
    i_fifo_stb  = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (wn_prev && !o_write_n) begin
      nfalls++;
      fall_cyc = cyc;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_beat observed=0x%0h expected=none",
               {o_register_data_sel, o_data_out});
      end else begin
        chk("sb_beat", {o_register_data_sel, o_data_out, o_data_oe}, {exp_q.pop_front(), 1'b1});
      end
    end
    if (!o_write_n) low_run++;
    else if (low_run > 0) begin last_low = low_run; low_run = 0; end
    if (o_write_n && o_data_oe) high_run++;
    else if (high_run > 0) begin last_high = high_run; high_run = 0; end
    if (!o_read_n) begin
      rlow_run++;
      if (o_data_oe) rd_oe_bad = 1'b1;
    end else if (rlow_run > 0) begin last_rlow = rlow_run; rlow_run = 0; end
    if (o_frame_done) fdone_cnt++;
    wn_prev = o_write_n;
  end

  initial begin
    int n, base, c0, fd0;
    rst = 1'b1; i_enable = 1'b1;
    i_wr_low_cycles = 4'd1; i_wr_high_cycles = 4'd1; i_rd_low_cycles = 4'd1;
    i_cmd_stb = 1'b0; i_cmd_read = 1'b0; i_cmd_is_param = 1'b0; i_cmd_data = '0;
    i_frame_start = 1'b0; i_num_pixels = '0; i_enable_tearing = 1'b0; i_tearing_effect = 1'b0;
    i_fifo_stb = 1'b0; i_fifo_data = '0; i_data_in = '0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    chk("rst_write_n", o_write_n, 1);
    chk("rst_read_n", o_read_n, 1);
    chk("rst_rs", o_register_data_sel, 1);
    chk("rst_oe", o_data_oe, 0);
    chk("rst_data_out", o_data_out, 0);
    chk("rst_cmd_data", o_cmd_data, 0);
    chk("rst_busy", {o_cmd_busy, o_frame_busy, o_cmd_done, o_frame_done}, 0);
    chk("rst_fifo", {o_fifo_full, o_fifo_overflow, o_fifo_count}, 0);

    // Command write: 2 low + 3 high cycles
    i_wr_low_cycles = 4'd2; i_wr_high_cycles = 4'd3;
    i_cmd_is_param = 1'b0; i_cmd_data = 8'h2C; i_cmd_read = 1'b0;
    exp_q.push_back({1'b0, 8'h2C});
    i_cmd_stb = 1'b1;
    tick();
    i_cmd_stb = 1'b0;
    chk("cmd_wr_busy", o_cmd_busy, 1);
    chk("cmd_wr_rs_low", o_register_data_sel, 0);
    n = 0;
    while (!o_cmd_done && n < 50) begin tick(); n++; end
    chk("cmd_wr_done_lat", n, 5);
    tick();
    chk("cmd_wr_done_pulse", o_cmd_done, 0);
    chk("cmd_wr_low_len", last_low, 2);
    chk("cmd_wr_high_len", last_high, 3);
    chk("cmd_wr_sb_empty", exp_q.size(), 0);
    chk("cmd_wr_idle", o_cmd_busy, 0);

    // Command read: 4 low cycles, bus value valid only on the last one
    i_rd_low_cycles = 4'd4; i_wr_high_cycles = 4'd1;
    i_cmd_is_param = 1'b1; i_cmd_read = 1'b1; i_data_in = 8'h3C;
    i_cmd_stb = 1'b1;
    tick();
    i_cmd_stb = 1'b0; i_cmd_read = 1'b0;
    tick(); tick(); tick();
    i_data_in = 8'h5A;
    tick();
    i_data_in = 8'hC3;
    n = 0;
    while (!o_cmd_done && n < 50) begin tick(); n++; end
    chk("cmd_rd_done_seen", o_cmd_done, 1);
    chk("cmd_rd_data", o_cmd_data, 8'h5A);
    chk("cmd_rd_rs", o_register_data_sel, 1);
    tick();
    chk("cmd_rd_low_len", last_rlow, 4);
    chk("cmd_rd_oe_low", rd_oe_bad, 0);

    // Frame of 3 beats from one word; the unused slice is discarded
    i_wr_low_cycles = 4'd1; i_wr_high_cycles = 4'd1;
    base = nfalls;
    push_word(32'h11223344);
    chk("frm3_count1", o_fifo_count, 1);
    exp_q.push_back({1'b1, 8'h11});
    exp_q.push_back({1'b1, 8'h22});
    exp_q.push_back({1'b1, 8'h33});
    i_num_pixels = 32'd3; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("frm3_busy", o_frame_busy, 1);
    n = 0;
    while (!o_frame_done && n < 100) begin tick(); n++; end
    chk("frm3_done_seen", o_frame_done, 1);
    chk("frm3_busy_end", o_frame_busy, 0);
    chk("frm3_count0", o_fifo_count, 0);
    tick();
    chk("frm3_beats", nfalls - base, 3);
    chk("frm3_sb_empty", exp_q.size(), 0);

    // Frame started on an empty FIFO stalls; zero timings behave as 1
    i_wr_low_cycles = 4'd0; i_wr_high_cycles = 4'd0;
    base = nfalls;
    i_num_pixels = 32'd6; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    repeat (5) tick();
    chk("frm6_stall_nofall", nfalls - base, 0);
    chk("frm6_stall_busy", o_frame_busy, 1);
    chk("frm6_stall_wn", o_write_n, 1);
    foreach (exp_q[i]) exp_q.delete(i);
    exp_q.push_back({1'b1, 8'hA1}); exp_q.push_back({1'b1, 8'hB2});
    exp_q.push_back({1'b1, 8'hC3}); exp_q.push_back({1'b1, 8'hD4});
    exp_q.push_back({1'b1, 8'h01}); exp_q.push_back({1'b1, 8'h02});
    push_word(32'hA1B2C3D4);
    push_word(32'h01020304);
    n = 0;
    while (!o_frame_done && n < 100) begin tick(); n++; end
    chk("frm6_done_seen", o_frame_done, 1);
    chk("frm6_count0", o_fifo_count, 0);
    chk("frm6_low_len_min", last_low, 1);
    chk("frm6_sb_empty", exp_q.size(), 0);

    // Zero-length frame: done next cycle, no strobes
    i_wr_low_cycles = 4'd1; i_wr_high_cycles = 4'd1;
    base = nfalls;
    i_num_pixels = 32'd0; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    chk("frm0_done", o_frame_done, 1);
    chk("frm0_busy", o_frame_busy, 0);
    tick();
    chk("frm0_done_pulse", o_frame_done, 0);
    chk("frm0_nofall", nfalls - base, 0);

    // Tearing sync: no beat before TE rises, and at least 3 cycles after it
    base = nfalls;
    push_word(32'hDEADBEEF);
    exp_q.push_back({1'b1, 8'hDE});
    i_enable_tearing = 1'b1; i_tearing_effect = 1'b0;
    i_num_pixels = 32'd1; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    repeat (20) tick();
    chk("te_nofall_before", nfalls - base, 0);
    chk("te_busy_wait", o_frame_busy, 1);
    i_tearing_effect = 1'b1;
    c0 = cyc;
    n = 0;
    while (nfalls == base && n < 50) begin tick(); n++; end
    chk("te_fell", nfalls - base, 1);
    chk("te_gap_ge3", (fall_cyc - c0) >= 3, 1);
    n = 0;
    while (!o_frame_done && n < 50) begin tick(); n++; end
    chk("te_done_seen", o_frame_done, 1);
    chk("te_count0", o_fifo_count, 0);
    i_enable_tearing = 1'b0; i_tearing_effect = 1'b0;

    // Enable drops during beat 2 of 10: beat 2 completes, FIFO flushed, no done
    i_wr_low_cycles = 4'd3; i_wr_high_cycles = 4'd2;
    push_word(32'h10203040);
    push_word(32'h55667788);
    push_word(32'h99AABBCC);
    chk("abort_count3", o_fifo_count, 3);
    base = nfalls; fd0 = fdone_cnt;
    exp_q.push_back({1'b1, 8'h10});
    exp_q.push_back({1'b1, 8'h20});
    i_num_pixels = 32'd10; i_frame_start = 1'b1;
    tick();
    i_frame_start = 1'b0;
    n = 0;
    while (nfalls < base + 2 && n < 100) begin tick(); n++; end
    chk("abort_in_beat2_wn", o_write_n, 0);
    i_enable = 1'b0;
    n = 0;
    while (o_frame_busy && n < 50) begin tick(); n++; end
    chk("abort_busy_drop", o_frame_busy, 0);
    repeat (5) tick();
    chk("abort_beats", nfalls - base, 2);
    chk("abort_beat2_low", last_low, 3);
    chk("abort_no_done", fdone_cnt - fd0, 0);
    chk("abort_flushed", o_fifo_count, 0);
    chk("abort_idle", o_cmd_busy, 0);
    chk("abort_sb_empty", exp_q.size(), 0);
    i_enable = 1'b1;

    // Fill the FIFO, then push once more while full
    for (int i = 0; i < 64; i++) push_word(32'(i));
    chk("fill_full", o_fifo_full, 1);
    chk("fill_count", o_fifo_count, 64);
    chk("fill_no_ovf", o_fifo_overflow, 0);
    push_word(32'hFFFF_FFFF);
    chk("ovf_set", o_fifo_overflow, 1);
    chk("ovf_count", o_fifo_count, 64);
    chk("ovf_full", o_fifo_full, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_rst_clear", o_fifo_overflow, 0);
    chk("ovf_rst_count", o_fifo_count, 0);
    chk("ovf_rst_full", o_fifo_full, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
